posit_mult: RTL and testbench
=============================

# posit_mult

Pipelined 32-bit posit multiplier (es = 2) for the Pair-HMM posit datapath. It multiplies two standard posits and returns the posit product rounded per the posit standard, plus zero/NaR flags. It accepts one operation per clock and has a fixed 3-cycle latency.

## Interface
- N, default 32: posit width.
- ES, default 2: exponent field width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in1  in  N  operand A, posit encoding.
- in2  in  N  operand B, posit encoding.
- start  in  1  operands valid this cycle.
- result  out  N  product, posit encoding.
- inf  out  1  result is NaR (0x80000000).
- zero  out  1  result is zero.
- done  out  1  result/inf/zero valid this cycle.

## Operation
- **Decode each operand.**
  - sign = MSB.
  - If the sign is set, take the two's complement first.
  - Regime is the run of identical bits after the sign: run of m ones gives k = m−1; run of m zeros gives k = −m.
  - Next ES bits are the exponent e; missing bits read as 0.
  - The remaining bits are the fraction, with a hidden 1 prepended.
- **Special cases:**
  - Either input is 0x80000000: result = 0x80000000, inf = 1, zero = 0. NaR wins over zero, so 0 × NaR = NaR.
  - Otherwise, either input is 0: result = 0, zero = 1, inf = 0.
- **Normal path:**
  - sign_out = s1 XOR s2.
  - scale = (k1·4 + e1) + (k2·4 + e2), signed 10-bit.
  - Mantissa product = 28×28 → 56 bits. If the product is ≥ 2.0, shift right by 1 and add 1 to scale.
- **Encode:**
  - k = scale >>> 2 (arithmetic); e = scale & 3.
  - Build the regime, exponent and fraction, then round.
  - Negate the result if sign_out = 1.
- **Saturation:**
  - scale ≥ 120 yields maxpos 0x7FFFFFFF (negated: 0x80000001).
  - scale ≤ −120 yields minpos 0x00000001 (negated: 0xFFFFFFFF).
  - A nonzero product never rounds to zero or NaR.

## Timing
- Reset values: result = 0, inf = 0, zero = 0, done = 0. All pipeline valid bits clear.
- done is asserted exactly 3 rising edges after start is sampled high: done = start delayed by 3.
- Fully pipelined: back-to-back start pulses each produce one done, in order.
- start low: the pipeline still advances. result/inf/zero may change; they are meaningful only while done = 1.
- Reset asserted mid-operation: all in-flight operations are discarded and no done is produced for them. The first valid start after reset release completes 3 cycles later.
- Stages:
  1. decode/special-case detection;
  2. mantissa multiply and scale sum;
  3. normalize/round/encode into output registers.

## Configuration
- POSIT_MULT_RNE_EN defined: round-to-nearest, ties-to-even.
  - Guard bit is the first discarded bit; sticky is the OR of the rest.
  - Rounding may carry into the regime/exponent.
- Undefined: truncation toward zero magnitude.
- Both modes: saturate to maxpos/minpos and never produce 0 or NaR from a nonzero finite product.

## Structure
- Package posit_pkg:
  - N, ES constants;
  - POSIT_ZERO, POSIT_NAR, POSIT_MAXPOS, POSIT_MINPOS;
  - typedef of the decoded posit struct {sign, zero, nar, signed regime k, exp, 28-bit mantissa};
  - scale width constant (10).
- Sub-module posit_extract: combinational decoder (leading-run count, shift, field split). Instantiated twice in stage 1.
- Encoder/rounder stays inline in positmult.

## Test plan
- 0x40000000 × 0x40000000 (1×1), start pulsed one cycle → 3 cycles later done = 1, result = 0x40000000, zero = 0, inf = 0.
- 0x48000000 × 0x48000000 (2×2) → 0x50000000. Then 0xC0000000 × 0x48000000 (−1×2) → 0xB8000000.
- Both operands 0x80003489 (large negative) → result 0x7FFFFFFF (maxpos saturation). Both operands 0x000020BE (tiny positive) → result 0x00000001 (minpos, not zero).
- 0x00000000 × 0x48000000 → result 0, zero = 1. 0x80000000 × 0x00000000 → result 0x80000000, inf = 1, zero = 0.
- Three consecutive start cycles with the vectors above → done high on three consecutive cycles with the results in order.
- rst asserted one cycle after start → no done pulse. All outputs read 0 immediately, asynchronously.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared constants, decoded-operand struct and helpers for the 32-bit posit
// (es = 2) multiplier datapath.
package posit_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned ES      = 2;
  localparam int unsigned BODY_W  = N - 1;          // magnitude bits after the sign
  localparam int unsigned RUN_W   = 6;              // regime run length 0..31
  localparam int unsigned K_W     = 7;              // signed regime value -31..30
  localparam int unsigned FRAC_W  = N - 3 - ES;     // widest possible fraction field
  localparam int unsigned MANT_W  = FRAC_W + 1;     // fraction with hidden one
  localparam int unsigned PROD_W  = 2 * MANT_W;     // full mantissa product
  localparam int unsigned SCALE_W = 10;             // signed scale (power of two)

  localparam logic [N-1:0] POSIT_ZERO   = N'(0);
  localparam logic [N-1:0] POSIT_NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] POSIT_MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] POSIT_MINPOS = N'(1);

  // |scale| at which the regime fills the whole word: maxpos = 2^120.
  localparam logic signed [SCALE_W-1:0] SCALE_SAT = SCALE_W'((N - 2) * (1 << ES));

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic                  nar;
    logic signed [K_W-1:0] k;
    logic [ES-1:0]         exp;
    logic [MANT_W-1:0]     mant;
  } posit_dec_t;

  // Power-of-two scale of a decoded operand: k * 2^ES + e.
  function automatic logic signed [SCALE_W-1:0] posit_scale(
    input logic signed [K_W-1:0] k,
    input logic [ES-1:0]         e
  );
    logic signed [K_W+ES-1:0] ke;
    ke = {k, e};
    return SCALE_W'(ke);
  endfunction

endpackage

// File: rtl/posit_extract.sv
// Combinational posit decoder: sign, special values, regime run, exponent
// and hidden-one mantissa.
module posit_extract
  import posit_pkg::*;
(
  input  logic [N-1:0] posit_i,
  output posit_dec_t   dec_o
);

  logic [BODY_W-1:0]     body;
  logic                  rbit;
  logic [RUN_W-1:0]      run;
  logic                  run_on;
  logic [BODY_W-3:0]     tail;
  logic signed [K_W-1:0] run_s;

  // Absolute value, leading-run count, then strip regime+terminator.
  always_comb begin
    body   = posit_i[N-1] ? (~posit_i[N-2:0] + BODY_W'(1)) : posit_i[N-2:0];
    rbit   = body[BODY_W-1];
    run    = '0;
    run_on = 1'b1;
    for (int i = BODY_W - 1; i >= 0; i--) begin
      if (run_on && (body[i] == rbit)) run = run + RUN_W'(1);
      else                             run_on = 1'b0;
    end
    // Top two body bits are always regime/terminator; the rest of the run
    // (run - 1 bits) is shifted out here, leaving exponent then fraction.
    tail  = body[BODY_W-3:0] << (run - RUN_W'(1));
    run_s = K_W'(run);

    dec_o.sign = posit_i[N-1];
    dec_o.zero = (posit_i == POSIT_ZERO);
    dec_o.nar  = (posit_i == POSIT_NAR);
    dec_o.k    = rbit ? (run_s - K_W'(1)) : -run_s;
    dec_o.exp  = tail[BODY_W-3 -: ES];
    dec_o.mant = {1'b1, tail[FRAC_W-1:0]};
  end

endmodule

// File: rtl/posit_mult.sv
// Three-stage pipelined posit<32,2> multiplier: decode, multiply, encode.
// Optional macro POSIT_MULT_RNE_EN selects round-to-nearest-even; otherwise
// the product is truncated toward zero magnitude. Both modes saturate to
// maxpos/minpos and never turn a nonzero product into zero or NaR.
module posit_mult
  import posit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] result,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int unsigned MAG_W   = N - 1;
  localparam int unsigned NFRAC_W = PROD_W - 1;                  // normalized fraction
  localparam int unsigned ENC_W   = 1 + ES + NFRAC_W + (N - 2);  // regime room below
  localparam int unsigned DROP_W  = ENC_W - MAG_W;

  // Stage 1: decoded operands
  posit_dec_t a_dec, b_dec, a_q, b_q;
  logic       v1_q;

  // Stage 2: product and scale
  logic [PROD_W-1:0]         prod_d, prod_q;
  logic signed [SCALE_W-1:0] scale_d, scale_q;
  logic                      sign2_q, nar2_q, zero2_q, v2_q;

  // Stage 3: encode
  logic                      norm_d;
  logic signed [SCALE_W-1:0] scale_n;
  logic signed [SCALE_W-1:0] k_enc;
  logic [NFRAC_W-1:0]        frac_n;
  logic                      rbit;
  logic [RUN_W-1:0]          run_n;
  logic [ENC_W-1:0]          base;
  logic [ENC_W-1:0]          shifted;
  logic [MAG_W-1:0]          mag;
`ifdef POSIT_MULT_RNE_EN
  logic                      guard;
  logic                      sticky;
`endif
  logic [N-1:0]              result_d, result_q;
  logic                      inf_d, inf_q, zero_d, zero_q, done_q;

  posit_extract u_dec_a (.posit_i(in1), .dec_o(a_dec));
  posit_extract u_dec_b (.posit_i(in2), .dec_o(b_dec));

  // Stage 1 registers: decoded operands and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= a_dec;
      b_q  <= b_dec;
      v1_q <= start;
    end
  end

  // Stage 2 next-state: 28x28 mantissa product and summed scale.
  always_comb begin
    prod_d  = PROD_W'(a_q.mant) * PROD_W'(b_q.mant);
    scale_d = posit_scale(a_q.k, a_q.exp) + posit_scale(b_q.k, b_q.exp);
  end

  // Stage 2 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      scale_q <= '0;
      sign2_q <= 1'b0;
      nar2_q  <= 1'b0;
      zero2_q <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      scale_q <= scale_d;
      sign2_q <= a_q.sign ^ b_q.sign;
      nar2_q  <= a_q.nar | b_q.nar;
      zero2_q <= a_q.zero | b_q.zero;
      v2_q    <= v1_q;
    end
  end

  // Stage 3 next-state: normalize, build regime/exponent/fraction, round,
  // saturate, apply sign and special cases.
  always_comb begin
    result_d = POSIT_ZERO;
    inf_d    = 1'b0;
    zero_d   = 1'b0;

    norm_d  = prod_q[PROD_W-1];
    scale_n = norm_d ? (scale_q + SCALE_W'(1)) : scale_q;
    frac_n  = norm_d ? prod_q[PROD_W-2:0] : {prod_q[PROD_W-3:0], 1'b0};
    k_enc   = scale_n >>> ES;
    rbit    = ~k_enc[SCALE_W-1];
    // Number of identical regime bits before the terminator.
    run_n   = rbit ? RUN_W'(k_enc + SCALE_W'(1)) : RUN_W'(-k_enc);

    // Terminator sits at the top; shifting right by the run length leaves
    // room for the run, which is then filled with ones for positive k.
    base    = {~rbit, scale_n[ES-1:0], frac_n, {(N-2){1'b0}}};
    shifted = base >> run_n;
    if (rbit) shifted = shifted | ~({ENC_W{1'b1}} >> run_n);
    mag     = MAG_W'(shifted >> DROP_W);

`ifdef POSIT_MULT_RNE_EN
    guard  = shifted[DROP_W-1];
    sticky = |shifted[DROP_W-2:0];
    if (guard && (sticky || mag[0])) mag = mag + MAG_W'(1);
`endif

    if (scale_n >= SCALE_SAT)       mag = POSIT_MAXPOS[MAG_W-1:0];
    else if (scale_n <= -SCALE_SAT) mag = POSIT_MINPOS[MAG_W-1:0];

    if (nar2_q) begin
      result_d = POSIT_NAR;
      inf_d    = 1'b1;
    end else if (zero2_q) begin
      result_d = POSIT_ZERO;
      zero_d   = 1'b1;
    end else begin
      result_d = sign2_q ? -{1'b0, mag} : {1'b0, mag};
    end
  end

  // Stage 3 output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      done_q   <= v2_q;
    end
  end

  assign result = result_q;
  assign inf    = inf_q;
  assign zero   = zero_q;
  assign done   = done_q;

endmodule

// File: tb/tb_posit_mult.sv
// Scoreboard bench for posit_mult: stimulus pushes expected responses, a
// negedge monitor pops them on every done pulse. The reference decodes
// posits bit-by-bit to exact (scale, fraction) values and finds the encoded
// result by binary search over the monotonic positive posit patterns.
`timescale 1ns/1ps
module tb_posit_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in1, in2;
  logic [31:0] result;
  logic        inf, zero, done;

  typedef struct {
    logic [31:0] res;
    logic        inf;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  posit_mult dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .start(start),
    .result(result), .inf(inf), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Decode nb magnitude bits (MSB first) into scale and a fraction with the
  // hidden one at bit 60.
  function automatic void pdec(input logic [31:0] bits, input int nb,
                               output int scale, output longint unsigned f60);
    int i, m, k, e, pos;
    logic r;
    i = nb - 1;
    r = bits[i];
    m = 0;
    while (i >= 0) begin
      if (bits[i] != r) break;
      m++;
      i--;
    end
    k = r ? m - 1 : -m;
    i--;
    e = 0;
    repeat (2) begin
      e = e * 2;
      if (i >= 0) begin
        if (bits[i]) e = e + 1;
      end
      i--;
    end
    f60 = 64'd1 << 60;
    pos = 59;
    while (i >= 0) begin
      if (bits[i]) f60 = f60 | (64'd1 << pos);
      pos--;
      i--;
    end
    scale = 4 * k + e;
  endfunction

  function automatic int cmpv(input int sa, input longint unsigned fa,
                              input int sb, input longint unsigned fb);
    if (sa != sb) return (sa < sb) ? -1 : 1;
    if (fa != fb) return (fa < fb) ? -1 : 1;
    return 0;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic inf_o,
                                output logic zero_o);
    logic [31:0] ma, mb, mag, lo, hi, mid;
    int sa, sb, sc, sp;
    longint unsigned fa, fb, prod, xf, fp;
`ifdef POSIT_MULT_RNE_EN
    int smid, c;
    longint unsigned fm;
`endif
    res = 32'h0; inf_o = 1'b0; zero_o = 1'b0;
    if (a == 32'h80000000 || b == 32'h80000000) begin
      res = 32'h80000000; inf_o = 1'b1; return;
    end
    if (a == 32'h0 || b == 32'h0) begin
      zero_o = 1'b1; return;
    end
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    pdec(ma, 31, sa, fa);
    pdec(mb, 31, sb, fb);
    prod = (fa >> 33) * (fb >> 33);
    sc = sa + sb;
    if (prod >= (64'd1 << 55)) begin
      sc++;
      xf = prod << 5;
    end else begin
      xf = prod << 6;
    end
    if (sc >= 120)       mag = 32'h7FFFFFFF;
    else if (sc <= -120) mag = 32'h00000001;
    else begin
      lo = 32'h1;
      hi = 32'h7FFFFFFF;
      while (lo < hi) begin
        mid = lo + (hi - lo + 32'd1) / 32'd2;
        pdec(mid, 31, sp, fp);
        if (cmpv(sp, fp, sc, xf) <= 0) lo = mid;
        else                           hi = mid - 32'd1;
      end
      mag = lo;
`ifdef POSIT_MULT_RNE_EN
      pdec(lo, 31, sp, fp);
      if (cmpv(sp, fp, sc, xf) != 0) begin
        pdec({lo[30:0], 1'b1}, 32, smid, fm);
        c = cmpv(sc, xf, smid, fm);
        if (c > 0 || (c == 0 && lo[0])) mag = lo + 32'd1;
      end
`endif
    end
    res = (a[31] ^ b[31]) ? -mag : mag;
  endfunction

  task automatic push_exp(input logic [31:0] r, input logic i, input logic z);
    exp_t e;
    e.res = r; e.inf = i; e.zero = z; e.cyc = cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic i, input logic z);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    push_exp(r, i, z);
  endtask

  task automatic issue_m(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic i, z;
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    model(a, b, r, i, z);
    push_exp(r, i, z);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] sp [8];
    logic [31:0] x;
    int sel;
    sp  = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h00000001,
            32'h40000000, 32'hC0000000, 32'h80000001, 32'hFFFFFFFF};
    sel = int'($urandom_range(0, 9));
    x   = $urandom;
    if (sel == 0) begin
      x = sp[$urandom_range(0, 7)];
    end else if (sel <= 4) begin
      x[30:0] = x[30:0] >> $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 1) x[30:0] = ~x[30:0];
    end
    return x;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("done_without_start", 32'(done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("result",  result,       e.res);
        chk("inf",     32'(inf),     32'(e.inf));
        chk("zero",    32'(zero),    32'(e.zero));
        chk("latency", 32'(cyc),     32'(e.cyc));
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", result,      32'h0);
    chk("reset_inf",    32'(inf),    32'(0));
    chk("reset_zero",   32'(zero),   32'(0));
    chk("reset_done",   32'(done),   32'(0));
    rst = 1'b0;
    idle(2);

    // Single operation: 1 x 1
    issue_exp(32'h40000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
    idle(5);

    // Back-to-back directed vectors
    issue_exp(32'h48000000, 32'h48000000, 32'h50000000, 1'b0, 1'b0);
    issue_exp(32'hC0000000, 32'h48000000, 32'hB8000000, 1'b0, 1'b0);
    issue_exp(32'h80003489, 32'h80003489, 32'h7FFFFFFF, 1'b0, 1'b0);
    issue_exp(32'h000020BE, 32'h000020BE, 32'h00000001, 1'b0, 1'b0);
    issue_exp(32'h80003489, 32'h7FFFCB77, 32'h80000001, 1'b0, 1'b0);
    issue_exp(32'h000020BE, 32'hFFFFDF42, 32'hFFFFFFFF, 1'b0, 1'b0);
    issue_exp(32'h00000000, 32'h48000000, 32'h00000000, 1'b0, 1'b1);
    issue_exp(32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
    issue_exp(32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
    idle(6);

    // Mid-flight reset: the in-flight operation must vanish.
    issue_exp(32'h48000000, 32'h48000000, 32'h50000000, 1'b0, 1'b0);
    idle(5);
    issue_exp(32'h48000000, 32'h48000000, 32'h50000000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", result,    32'h0);
    chk("async_rst_inf",    32'(inf),  32'(0));
    chk("async_rst_zero",   32'(zero), 32'(0));
    chk("async_rst_done",   32'(done), 32'(0));
    exp_q.delete();
    n0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("no_done_after_rst", 32'(done_cnt), 32'(n0));
    issue_exp(32'h40000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
    idle(5);

    // Randomized traffic against the reference model
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 9) < 7) issue_m(rand_op(), rand_op());
      else                          idle(1);
    end
    idle(1);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    chk("drain_outstanding", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
